// File: rtl/mem_access.sv
// MEM-stage load/store engine: drives a req/ack data bus with big-endian byte lanes,
// extends load data, and passes non-memory results straight through to MEM/WB.
module mem_access #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);

  localparam int CW = $clog2(ACK_TIMEOUT);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic [31:0]     rdata_q_r, rdata_nx_s;
  logic            err_r, err_nx_s;

  logic is_load_s, is_store_s, sz_byte_s, sz_half_s, sz_word_s, misalign_s;

  // Byte enables for an access of the given size at the given word offset.
  function automatic logic [3:0] lane_be(input logic is_byte, input logic is_half,
                                         input logic [1:0] a);
    logic [3:0] be;
    if (is_byte) begin
      case (a)
        2'd0:    be = 4'b1000;
        2'd1:    be = 4'b0100;
        2'd2:    be = 4'b0010;
        default: be = 4'b0001;
      endcase
    end else if (is_half) begin
      be = a[1] ? 4'b0011 : 4'b1100;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Store data replicated across every lane the access could hit.
  function automatic logic [31:0] store_rep(input logic is_byte, input logic is_half,
                                            input logic [31:0] d);
    logic [31:0] r;
    if (is_byte) begin
      r = {4{d[7:0]}};
    end else if (is_half) begin
      r = {2{d[15:0]}};
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Selects the addressed lane of a read word and sign/zero extends it.
  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Operation class and alignment decode.
  always_comb begin
    is_load_s  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    is_store_s = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    sz_byte_s  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
    sz_half_s  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    sz_word_s  = (mem_op == OP_LW) || (mem_op == OP_SW);
    misalign_s = (sz_half_s && mem_addr[0]) || (sz_word_s && (mem_addr[1:0] != 2'd0));
  end

  // Next-state logic and all outputs; reset masks every output in its own cycle.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    rdata_nx_s = rdata_q_r;
    err_nx_s   = err_r;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'd0;
    dbus_be    = 4'd0;
    dbus_wdata = 32'd0;
    wb_wd      = mem_wd;
    wb_wreg    = mem_wreg;
    wb_wdata   = mem_wdata;
    stallreq   = 1'b0;
    adel       = 1'b0;
    ades       = 1'b0;
    bus_err    = 1'b0;
    if (rst) begin
      wb_wd    = 5'd0;
      wb_wreg  = 1'b0;
      wb_wdata = 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_load_s || is_store_s) begin
            wb_wreg = 1'b0;
            if (misalign_s) begin
              adel = is_load_s;
              ades = is_store_s;
            end else begin
              stallreq   = 1'b1;
              state_nx_s = REQ;
              cnt_nx_s   = {CW{1'b0}};
              err_nx_s   = 1'b0;
            end
          end else begin
            stallreq = 1'b0;
          end
        end
        REQ: begin
          dbus_req   = 1'b1;
          stallreq   = 1'b1;
          wb_wreg    = 1'b0;
          dbus_we    = is_store_s;
          dbus_addr  = {mem_addr[31:2], 2'b00};
          dbus_be    = lane_be(sz_byte_s, sz_half_s, mem_addr[1:0]);
          dbus_wdata = store_rep(sz_byte_s, sz_half_s, mem_sdata);
          if (dbus_ack) begin
            rdata_nx_s = dbus_rdata;
            state_nx_s = DONE;
          end else if (cnt_r == CW'(ACK_TIMEOUT - 1)) begin
            err_nx_s   = 1'b1;
            state_nx_s = DONE;
          end else begin
            cnt_nx_s = cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_nx_s = IDLE;
          err_nx_s   = 1'b0;
          if (err_r) begin
            bus_err = 1'b1;
            wb_wreg = 1'b0;
          end else if (is_load_s) begin
            wb_wdata = load_ext(mem_op, mem_addr[1:0], rdata_q_r);
            wb_wreg  = mem_wreg;
          end else begin
            wb_wreg = 1'b0;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // State, timeout counter, captured read data and abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      rdata_q_r <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      rdata_q_r <= rdata_nx_s;
      err_r     <= err_nx_s;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: bus responder driven per op, expected
// writeback results queued at issue and compared when the access completes.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq, adel, ades, bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        err;
    int          nreq;
    int          nstall;
  } exp_t;

  exp_t sb_q[$];

  mem_access #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .adel(adel), .ades(ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    case (op)
      4'd1: begin v = rd >> ((3 - a) * 8);     return {{24{v[7]}}, v[7:0]}; end
      4'd2: begin v = rd >> ((3 - a) * 8);     return {24'd0, v[7:0]}; end
      4'd3: begin v = rd >> ((1 - a[1]) * 16); return {{16{v[15]}}, v[15:0]}; end
      4'd4: begin v = rd >> ((1 - a[1]) * 16); return {16'd0, v[15:0]}; end
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [1:0] a);
    logic [3:0] one_b;
    one_b = 4'b1000;
    if (op == 4'd1 || op == 4'd2 || op == 4'd6) return one_b >> a;
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  // Issues one aligned access; ack_at = REQ cycle carrying the ack, 0 = never.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int ack_at);
    exp_t e, g;
    int nreq, nstall;
    bit done, is_store;
    logic [31:0] exp_wd;
    is_store = (op >= 4'd6);
    e.err      = (ack_at == 0);
    e.wreg     = (!is_store && !e.err);
    e.wdata    = model_load(op, addr[1:0], rdata);
    e.chk_data = e.wreg;
    e.nreq     = e.err ? 16 : ack_at;
    e.nstall   = e.nreq + 1;
    sb_q.push_back(e);
    mem_op = op; mem_addr = addr; mem_sdata = sdata;
    mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_0000;
    if (op == 4'd6)      exp_wd = {4{sdata[7:0]}};
    else if (op == 4'd7) exp_wd = {2{sdata[15:0]}};
    else                 exp_wd = sdata;
    nreq = 0; nstall = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (dbus_req) begin
        nreq++;
        if (nreq == 1) begin
          check_val("bus_addr", dbus_addr, {addr[31:2], 2'b00});
          check_val("bus_be", {28'd0, dbus_be}, {28'd0, model_be(op, addr[1:0])});
          check_val("bus_we", {31'd0, dbus_we}, {31'd0, is_store});
          if (is_store) check_val("bus_wdata", dbus_wdata, exp_wd);
        end
        if (nreq == ack_at) begin
          dbus_ack = 1'b1;
          dbus_rdata = rdata;
        end
      end
      if (stallreq) begin
        nstall++;
      end else if (nreq > 0) begin
        done = 1;
        g = sb_q.pop_front();
        check_val("wb_wreg", {31'd0, wb_wreg}, {31'd0, g.wreg});
        if (g.chk_data) check_val("wb_wdata", wb_wdata, g.wdata);
        check_val("bus_err", {31'd0, bus_err}, {31'd0, g.err});
        check_val("req_cycles", nreq, g.nreq);
        check_val("stall_cycles", nstall, g.nstall);
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0;
    end
    if (!done) check_val("op_timeout", 32'd0, 32'd1);
    mem_op = 4'd0;
  endtask

  initial begin
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    mem_op = 4'd0; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
    mem_addr = 32'd0; mem_sdata = 32'd0;
    @(posedge clk); #4;
    check_val("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
    check_val("rst_wb_wdata", wb_wdata, 32'd0);
    check_val("rst_wb_wd", {27'd0, wb_wd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    check_val("none_wd", {27'd0, wb_wd}, 32'd5);
    check_val("none_wreg", {31'd0, wb_wreg}, 32'd1);
    check_val("none_wdata", wb_wdata, 32'h1234);
    check_val("none_stall", {31'd0, stallreq}, 32'd0);
    check_val("none_req", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;

    run_op(4'd1, 32'h101, 32'd0, 32'h1180_2233, 1);
    run_op(4'd2, 32'h101, 32'd0, 32'h1180_2233, 1);
    run_op(4'd7, 32'h202, 32'hAAAA_BEEF, 32'd0, 4);
    run_op(4'd3, 32'h102, 32'd0, 32'h1234_8765, 2);
    run_op(4'd4, 32'h100, 32'd0, 32'h9234_8765, 1);
    run_op(4'd1, 32'h103, 32'd0, 32'h0000_00F3, 3);
    run_op(4'd5, 32'h104, 32'd0, 32'hCAFE_F00D, 1);
    run_op(4'd6, 32'h301, 32'h0000_00A5, 32'd0, 1);
    run_op(4'd8, 32'h308, 32'h1357_9BDF, 32'd0, 2);
    run_op(4'd5, 32'h400, 32'd0, 32'd0, 0);

    mem_op = 4'd5; mem_addr = 32'h3; mem_wreg = 1'b1;
    #4;
    check_val("lw_adel", {31'd0, adel}, 32'd1);
    check_val("lw_ades", {31'd0, ades}, 32'd0);
    check_val("lw_mis_req", {31'd0, dbus_req}, 32'd0);
    check_val("lw_mis_stall", {31'd0, stallreq}, 32'd0);
    check_val("lw_mis_wreg", {31'd0, wb_wreg}, 32'd0);
    @(posedge clk); #1;
    mem_op = 4'd8; mem_addr = 32'h6;
    #4;
    check_val("sw_ades", {31'd0, ades}, 32'd1);
    check_val("sw_adel", {31'd0, adel}, 32'd0);
    check_val("sw_mis_req", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;

    mem_op = 4'd5; mem_addr = 32'h400; mem_wreg = 1'b1; mem_wd = 5'd9;
    @(posedge clk); #1;
    #4;
    check_val("rr_req1", {31'd0, dbus_req}, 32'd1);
    @(posedge clk); #1;
    #4;
    rst = 1'b1;
    #1;
    check_val("rr_req", {31'd0, dbus_req}, 32'd0);
    check_val("rr_stall", {31'd0, stallreq}, 32'd0);
    check_val("rr_wreg", {31'd0, wb_wreg}, 32'd0);
    check_val("rr_wdata", wb_wdata, 32'd0);
    check_val("rr_wd", {27'd0, wb_wd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_op = 4'd0; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    #4;
    check_val("post_rst_req", {31'd0, dbus_req}, 32'd0);
    check_val("post_rst_stall", {31'd0, stallreq}, 32'd0);
    check_val("post_rst_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    #4;
    check_val("late_ack_req", {31'd0, dbus_req}, 32'd0);
    check_val("late_ack_stall", {31'd0, stallreq}, 32'd0);
    check_val("queue_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
